alu_pipe: RTL and testbench

Parametrised, pipelined successor to the 16-bit ripple ALU used as the BIST design-under-test. It keeps the same operation set and encoding, with these extensions:
- configurable data width;
- the carry chain split into registered segments;
- a valid/ready handshake on input and output;
- a full flag set (carry, zero, negative, overflow).

It sits between the BIST pattern generator (upstream) and the response compactor (downstream).

---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu_seg.sv | 36 +++
 rtl/alu_pipe.sv | 167 ++++++++++++++++
 tb/tb_alu_pipe.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined BIST ALU.
// Holds the op encodings and the flag bit positions used by the response compactor.
package alu_pkg;

    typedef enum logic [1:0] {
        ALU_AND = 2'b00,
        ALU_OR  = 2'b01,
        ALU_ADD = 2'b10,
        ALU_SUB = 2'b11
    } alu_op_e;

    localparam int FLAG_C = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 3;
    localparam int FLAG_W = 4;

    function automatic logic op_is_sub(input logic [1:0] sel);
        return sel == ALU_SUB;
    endfunction

endpackage

// File: rtl/alu_seg.sv
// Combinational SEG-bit ALU slice.
// SUB inverts b locally; the caller supplies the carry-in (1 for the lowest SUB slice).
module alu_seg #(
    parameter int SEG = 8
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           cin,
    input  logic [1:0]     alu_sel,
    output logic [SEG-1:0] result,
    output logic           cout
);
    import alu_pkg::*;

    logic [SEG-1:0] b_eff;
    logic [SEG:0]   sum;

    always_comb begin
        b_eff  = op_is_sub(alu_sel) ? ~b : b;
        sum    = {1'b0, a} + {1'b0, b_eff} + {{SEG{1'b0}}, cin};
        result = sum[SEG-1:0];
        cout   = sum[SEG];
        case (alu_sel)
            ALU_AND: begin
                result = a & b;
                cout   = 1'b0;
            end
            ALU_OR: begin
                result = a | b;
                cout   = 1'b0;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_pipe.sv
// Pipelined ALU: the carry chain is cut into STAGES registered segments with a
// valid/ready handshake; every stage advances together when the output can move.
module alu_pipe #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       alu_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             zero,
    output logic             neg,
    output logic             ovf
);
    import alu_pkg::*;

    localparam int SEG  = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;
    localparam int MID  = (STAGES > 1) ? STAGES - 1 : 1;

    logic adv;

    logic             stg_valid  [STAGES];
    logic [WIDTH-1:0] stg_a      [STAGES];
    logic [WIDTH-1:0] stg_b      [STAGES];
    logic [1:0]       stg_sel    [STAGES];
    logic             stg_cin    [STAGES];
    logic [WIDTH-1:0] stg_res_in [STAGES];
    logic [SEG-1:0]   seg_res    [STAGES];
    logic             seg_cout   [STAGES];

    // Inter-stage registers: operands are kept right-aligned so the next slice
    // always reads the low SEG bits; partial results fill in from the top.
    logic             mid_valid_q [MID];
    logic             mid_valid_d [MID];
    logic [WIDTH-1:0] mid_a_q     [MID];
    logic [WIDTH-1:0] mid_a_d     [MID];
    logic [WIDTH-1:0] mid_b_q     [MID];
    logic [WIDTH-1:0] mid_b_d     [MID];
    logic [1:0]       mid_sel_q   [MID];
    logic [1:0]       mid_sel_d   [MID];
    logic             mid_carry_q [MID];
    logic             mid_carry_d [MID];
    logic [WIDTH-1:0] mid_res_q   [MID];
    logic [WIDTH-1:0] mid_res_d   [MID];

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q, cout_d;
    logic             zero_q, zero_d;
    logic             neg_q, neg_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH+SEG-1:0] merged;
    logic                 a_msb;
    logic                 bp_msb;

    assign adv       = !out_valid_q || out_ready;
    assign in_ready  = adv;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign cout      = cout_q;
    assign zero      = zero_q;
    assign neg       = neg_q;
    assign ovf       = ovf_q;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign stg_valid[k]  = in_valid;
            assign stg_a[k]      = a;
            assign stg_b[k]      = b;
            assign stg_sel[k]    = alu_sel;
            assign stg_cin[k]    = op_is_sub(alu_sel);
            assign stg_res_in[k] = '0;
        end else begin : g_body
            assign stg_valid[k]  = mid_valid_q[k-1];
            assign stg_a[k]      = mid_a_q[k-1];
            assign stg_b[k]      = mid_b_q[k-1];
            assign stg_sel[k]    = mid_sel_q[k-1];
            assign stg_cin[k]    = mid_carry_q[k-1];
            assign stg_res_in[k] = mid_res_q[k-1];
        end

        alu_seg #(.SEG(SEG)) u_seg (
            .a       (stg_a[k][SEG-1:0]),
            .b       (stg_b[k][SEG-1:0]),
            .cin     (stg_cin[k]),
            .alu_sel (stg_sel[k]),
            .result  (seg_res[k]),
            .cout    (seg_cout[k])
        );
    end

    always_comb begin
        for (int k = 0; k < MID; k++) begin
            mid_valid_d[k] = 1'b0;
            mid_a_d[k]     = '0;
            mid_b_d[k]     = '0;
            mid_sel_d[k]   = '0;
            mid_carry_d[k] = 1'b0;
            mid_res_d[k]   = '0;
        end
        for (int k = 0; k < LAST; k++) begin
            merged         = {seg_res[k], stg_res_in[k]};
            mid_valid_d[k] = stg_valid[k];
            mid_a_d[k]     = stg_a[k] >> SEG;
            mid_b_d[k]     = stg_b[k] >> SEG;
            mid_sel_d[k]   = stg_sel[k];
            mid_carry_d[k] = seg_cout[k];
            mid_res_d[k]   = merged[WIDTH+SEG-1:SEG];
        end

        merged      = {seg_res[LAST], stg_res_in[LAST]};
        result_d    = merged[WIDTH+SEG-1:SEG];
        out_valid_d = stg_valid[LAST];
        cout_d      = seg_cout[LAST];
        zero_d      = (result_d == '0);
        neg_d       = result_d[WIDTH-1];
        // The top slice still holds the operand MSBs; b is taken after SUB inversion.
        a_msb       = stg_a[LAST][SEG-1];
        bp_msb      = stg_b[LAST][SEG-1] ^ op_is_sub(stg_sel[LAST]);
        ovf_d       = (stg_sel[LAST] == ALU_ADD || stg_sel[LAST] == ALU_SUB)
                      && (a_msb == bp_msb) && (result_d[WIDTH-1] != a_msb);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < MID; k++) begin
                mid_valid_q[k] <= 1'b0;
                mid_a_q[k]     <= '0;
                mid_b_q[k]     <= '0;
                mid_sel_q[k]   <= '0;
                mid_carry_q[k] <= 1'b0;
                mid_res_q[k]   <= '0;
            end
            out_valid_q <= 1'b0;
            result_q    <= '0;
            cout_q      <= 1'b0;
            zero_q      <= 1'b0;
            neg_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else if (adv) begin
            for (int k = 0; k < MID; k++) begin
                mid_valid_q[k] <= mid_valid_d[k];
                mid_a_q[k]     <= mid_a_d[k];
                mid_b_q[k]     <= mid_b_d[k];
                mid_sel_q[k]   <= mid_sel_d[k];
                mid_carry_q[k] <= mid_carry_d[k];
                mid_res_q[k]   <= mid_res_d[k];
            end
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            cout_q      <= cout_d;
            zero_q      <= zero_d;
            neg_q       <= neg_d;
            ovf_q       <= ovf_d;
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: three instances (STAGES 4, 1, 16), a queue-based
// reference model per instance, and directed scenarios for reset, latency and stalls.
module tb_alu_pipe;
    import alu_pkg::*;

    localparam int NDUT = 3;

    logic        clk;
    logic        rst;
    logic        in_valid  [NDUT];
    logic        in_ready  [NDUT];
    logic [15:0] a_in      [NDUT];
    logic [15:0] b_in      [NDUT];
    logic [1:0]  sel_in    [NDUT];
    logic        out_valid [NDUT];
    logic        out_ready [NDUT];
    logic [15:0] res       [NDUT];
    logic        cout      [NDUT];
    logic        zero      [NDUT];
    logic        neg       [NDUT];
    logic        ovf       [NDUT];

    int checks;
    int errors;

    logic [19:0] exp_q [NDUT][$];
    int acc_cnt  [NDUT];
    int cons_cnt [NDUT];

    logic [15:0] va [32];
    logic [15:0] vb [32];
    logic [1:0]  vs [32];

    logic [15:0] dir_a [8];
    logic [15:0] dir_b [8];
    logic [1:0]  dir_s [8];
    logic [19:0] dir_e [8];

    alu_pipe #(.WIDTH(16), .STAGES(4)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .a(a_in[0]), .b(b_in[0]), .alu_sel(sel_in[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .result(res[0]), .cout(cout[0]), .zero(zero[0]),
        .neg(neg[0]), .ovf(ovf[0])
    );

    alu_pipe #(.WIDTH(16), .STAGES(1)) u_dut_s1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .a(a_in[1]), .b(b_in[1]), .alu_sel(sel_in[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .result(res[1]), .cout(cout[1]), .zero(zero[1]),
        .neg(neg[1]), .ovf(ovf[1])
    );

    alu_pipe #(.WIDTH(16), .STAGES(16)) u_dut_s16 (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .a(a_in[2]), .b(b_in[2]), .alu_sel(sel_in[2]), .out_valid(out_valid[2]),
        .out_ready(out_ready[2]), .result(res[2]), .cout(cout[2]), .zero(zero[2]),
        .neg(neg[2]), .ovf(ovf[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // Reference: packed {cout, zero, neg, ovf, result[15:0]} from integer arithmetic.
    function automatic logic [19:0] ref_calc(input logic [15:0] x, input logic [15:0] y,
                                             input logic [1:0] op);
        int ua, ub, sa, sb, r;
        logic c, v;
        logic [15:0] rr;
        ua = int'(x);
        ub = int'(y);
        sa = int'($signed(x));
        sb = int'($signed(y));
        c  = 1'b0;
        v  = 1'b0;
        rr = '0;
        case (op)
            ALU_AND: rr = x & y;
            ALU_OR:  rr = x | y;
            ALU_ADD: begin
                r  = ua + ub;
                rr = r[15:0];
                c  = (r > 65535);
                v  = (sa + sb > 32767) || (sa + sb < -32768);
            end
            default: begin
                r  = ua - ub;
                rr = r[15:0];
                c  = (ua >= ub);
                v  = (sa - sb > 32767) || (sa - sb < -32768);
            end
        endcase
        return {c, (rr == 16'h0000), rr[15], v, rr};
    endfunction

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < NDUT; d++) begin
            if (rst) begin
                exp_q[d].delete();
            end else begin
                if (out_valid[d]) begin
                    if (exp_q[d].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL out_unexpected_dut%0d actual=%h required=no beat", d, res[d]);
                    end else begin
                        check_eq($sformatf("out_dut%0d", d),
                                 {12'h0, cout[d], zero[d], neg[d], ovf[d], res[d]},
                                 {12'h0, exp_q[d][0]});
                        if (out_ready[d]) begin
                            void'(exp_q[d].pop_front());
                            cons_cnt[d]++;
                        end
                    end
                end
                if (in_valid[d] && in_ready[d]) begin
                    exp_q[d].push_back(ref_calc(a_in[d], b_in[d], sel_in[d]));
                    acc_cnt[d]++;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic latency_add(input int d, input int st);
        a_in[d]      = 16'hFFFF;
        b_in[d]      = 16'h0001;
        sel_in[d]    = ALU_ADD;
        in_valid[d]  = 1'b1;
        out_ready[d] = 1'b1;
        step();
        in_valid[d] = 1'b0;
        for (int i = 1; i < st; i++) begin
            check_eq($sformatf("lat_early_dut%0d", d), out_valid[d], 0);
            step();
        end
        check_eq($sformatf("lat_valid_dut%0d", d), out_valid[d], 1);
        check_eq($sformatf("lat_data_dut%0d", d),
                 {12'h0, cout[d], zero[d], neg[d], ovf[d], res[d]}, 32'h000C0000);
        step();
    endtask

    task automatic stream(input int n, input logic [31:0] stall_mask,
                          output int cycles, output int stalls);
        int sent;
        int cyc;
        bit acc;
        sent   = 0;
        cyc    = 0;
        stalls = 0;
        while (sent < n && cyc < 200) begin
            a_in[0]      = va[sent];
            b_in[0]      = vb[sent];
            sel_in[0]    = vs[sent];
            in_valid[0]  = 1'b1;
            out_ready[0] = (cyc < 32) ? !stall_mask[cyc] : 1'b1;
            @(negedge clk);
            check_eq("in_ready_rule", in_ready[0], (!out_valid[0] || out_ready[0]));
            if (!out_ready[0] && !in_ready[0]) stalls++;
            acc = in_ready[0];
            step();
            if (acc) sent++;
            cyc++;
        end
        check_eq("stream_all_sent", sent, n);
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b1;
        cycles = cyc;
    endtask

    task automatic drain(output int steps);
        steps = 0;
        while (exp_q[0].size() > 0 && steps < 50) begin
            step();
            steps++;
        end
        check_eq("drain_empty", exp_q[0].size(), 0);
    endtask

    initial begin
        int cyc, stl, dr, c0, a0;
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        for (int d = 0; d < NDUT; d++) begin
            in_valid[d]  = 1'b0;
            out_ready[d] = 1'b1;
            a_in[d]      = '0;
            b_in[d]      = '0;
            sel_in[d]    = '0;
            acc_cnt[d]   = 0;
            cons_cnt[d]  = 0;
        end

        dir_a = '{16'hFFFF, 16'h7FFF, 16'h8000, 16'h0000, 16'hF0F0, 16'hF0F0, 16'h8000, 16'h0005};
        dir_b = '{16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0FF0, 16'h0FF0, 16'h8000, 16'h0005};
        dir_s = '{ALU_ADD, ALU_ADD, ALU_SUB, ALU_SUB, ALU_AND, ALU_OR, ALU_ADD, ALU_SUB};
        dir_e = '{20'hC0000, 20'h38000, 20'h97FFF, 20'h2FFFF,
                  20'h000F0, 20'h2FFF0, 20'hD0000, 20'hC0000};

        // Reset held two cycles with a beat offered.
        in_valid[0] = 1'b1;
        a_in[0]     = 16'h1234;
        b_in[0]     = 16'h4321;
        sel_in[0]   = ALU_ADD;
        step();
        step();
        check_eq("rst_out_valid", out_valid[0], 0);
        check_eq("rst_result", res[0], 0);
        check_eq("rst_flags", {cout[0], zero[0], neg[0], ovf[0]}, 0);
        rst         = 1'b0;
        in_valid[0] = 1'b0;
        check_eq("rel_in_ready", in_ready[0], 1);
        step();
        for (int d = 0; d < NDUT; d++) begin
            check_eq($sformatf("post_rst_in_ready_dut%0d", d), in_ready[d], 1);
            check_eq($sformatf("post_rst_out_valid_dut%0d", d), out_valid[d], 0);
        end

        for (int i = 0; i < 8; i++)
            check_eq($sformatf("model_pin%0d", i), ref_calc(dir_a[i], dir_b[i], dir_s[i]), dir_e[i]);

        latency_add(0, 4);
        latency_add(1, 1);
        latency_add(2, 16);

        // Directed vectors back-to-back.
        for (int i = 0; i < 8; i++) begin
            va[i] = dir_a[i];
            vb[i] = dir_b[i];
            vs[i] = dir_s[i];
        end
        stream(8, 32'h0, cyc, stl);
        check_eq("dir_cycles", cyc, 8);
        drain(dr);
        check_eq("dir_drain_steps", dr, 4);

        // Random stream, one beat per cycle.
        for (int i = 0; i < 16; i++) begin
            va[i] = 16'($urandom);
            vb[i] = 16'($urandom);
            vs[i] = 2'($urandom);
        end
        va[3] = 16'hFFFF; vb[3] = 16'h0001; vs[3] = ALU_ADD;
        va[9] = 16'h8000; vb[9] = 16'h7FFF; vs[9] = ALU_SUB;
        c0 = cons_cnt[0];
        stream(16, 32'h0, cyc, stl);
        check_eq("rnd_cycles", cyc, 16);
        drain(dr);
        check_eq("rnd_drain_steps", dr, 4);
        check_eq("rnd_consumed", cons_cnt[0] - c0, 16);

        // Backpressure: output not ready for three cycles once the pipe is full.
        for (int i = 0; i < 12; i++) begin
            va[i] = 16'($urandom);
            vb[i] = 16'($urandom);
            vs[i] = 2'($urandom);
        end
        c0 = cons_cnt[0];
        a0 = acc_cnt[0];
        stream(12, 32'h0000_01C0, cyc, stl);
        check_eq("bp_stall_cycles", stl, 3);
        check_eq("bp_cycles", cyc, 15);
        drain(dr);
        check_eq("bp_accepted", acc_cnt[0] - a0, 12);
        check_eq("bp_consumed", cons_cnt[0] - c0, 12);

        // Reset with four beats in flight.
        for (int i = 0; i < 4; i++) begin
            va[i] = 16'($urandom);
            vb[i] = 16'($urandom);
            vs[i] = 2'($urandom);
        end
        stream(4, 32'hFFFF_FFFF, cyc, stl);
        check_eq("mid_cycles", cyc, 4);
        out_ready[0] = 1'b0;
        rst          = 1'b1;
        step();
        check_eq("midrst_out_valid", out_valid[0], 0);
        check_eq("midrst_in_ready", in_ready[0], 1);
        rst          = 1'b0;
        out_ready[0] = 1'b1;
        c0 = cons_cnt[0];
        repeat (8) step();
        check_eq("midrst_no_ghost", cons_cnt[0] - c0, 0);

        latency_add(0, 4);

        for (int d = 0; d < NDUT; d++)
            check_eq($sformatf("final_empty_dut%0d", d), exp_q[d].size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
